// File: rtl/eclk_sched_pkg.sv
// rtl/eclk_sched_pkg.sv - shared types and constants for the E-clock access scheduler
//
// Holds the scheduler state enum, the E phase numbers that bound the CIA data
// phase, the read value returned on a timed-out access, and a helper that
// decodes a one-hot E phase vector.
package eclk_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACTIVE,
    ST_RECOVER
  } sched_state_t;

  // E-high (CIA data phase) spans phases 6..9: enter after phase 5 ends,
  // leave when phase 9 ends.
  localparam int PH_START = 5;
  localparam int PH_LAST  = 9;

  localparam logic [7:0] RD_ERR_VAL = 8'hFF;

  // True only when eclk is exactly the one-hot code for phase k; a vector
  // that is not one-hot matches no phase.
  function automatic logic phase_is(input logic [9:0] eclk, input int k);
    return eclk == (10'd1 << k);
  endfunction

endpackage

// File: rtl/eclk_rr_arb.sv
// rtl/eclk_rr_arb.sv - two-input round-robin arbiter with last-grant memory
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req[1:0]    request levels
//   load        commit the current grant as the new last-grant
//   grant       index of the winning port (combinational)
//   valid       at least one request is pending
//
// Last-grant resets to 1 so that port 0 wins the first contention.
module eclk_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       load,
  output logic       grant,
  output logic       valid
);

  logic last_grant;

  always_comb begin
    valid = |req;
    if (req == 2'b11) grant = ~last_grant;
    else              grant = req[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              last_grant <= 1'b1;
    else if (load && valid)  last_grant <= grant;
  end

endmodule

// File: rtl/eclk_access_sched.sv
// rtl/eclk_access_sched.sv - E-clock aligned CIA access scheduler for two requesters
//
// Sequences 6800-style CIA accesses on the 28 MHz clock so that the CIA data
// phase covers exactly E-high (phases 6..9). Port 0 is the CPU, port 1 the
// host/OSD port; they are served round-robin.
//
// Ports:
//   clk, rst_n          28 MHz clock, asynchronous active-low reset
//   clk7_en             one-clk pulse at each clk7 phase boundary
//   eclk[9:0]           one-hot E phase, eclk[k] at clk7_en = phase k ending
//   req, we             per-port request level and write flag
//   addr0/1, wdata0/1   per-port address and write data
//   ack, err, rdata     completion pulse per port, timeout flag, read data
//   cia_sel, cia_we     CIA select (E-high window) and write qualifier
//   cia_addr, cia_wdata CIA address and write data
//   cia_rdata           CIA read data
//
// Optional feature macro: ECLK_SCHED_TIMEOUT_EN adds a WAIT timeout that
// aborts the access with err=1 after TO_PHASES clk7 periods.
module eclk_access_sched #(
  parameter int ADDR_W    = 4,
  parameter int TO_PHASES = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk7_en,
  input  logic [9:0]        eclk,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [7:0]        rdata,
  output logic              cia_sel,
  output logic              cia_we,
  output logic [ADDR_W-1:0] cia_addr,
  output logic [7:0]        cia_wdata,
  input  logic [7:0]        cia_rdata
);

  import eclk_sched_pkg::*;

  sched_state_t state;
  logic         gnt;
  logic         lat_we;
  logic         arb_grant;
  logic         arb_valid;
  logic         arb_load;
  logic         ph_start;
  logic         ph_last;

  assign ph_start = clk7_en && phase_is(eclk, PH_START);
  assign ph_last  = clk7_en && phase_is(eclk, PH_LAST);
  assign arb_load = clk7_en && (state == ST_IDLE);

  eclk_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .load  (arb_load),
    .grant (arb_grant),
    .valid (arb_valid)
  );

`ifdef ECLK_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_PHASES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  // to_cnt holds the number of WAIT boundaries already passed, so the
  // boundary that would make it TO_PHASES is the one that aborts.
  assign to_hit = (to_cnt == TO_W'(TO_PHASES - 1));
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      cia_sel   <= 1'b0;
      cia_we    <= 1'b0;
      cia_addr  <= '0;
      cia_wdata <= '0;
      rdata     <= '0;
      ack       <= '0;
`ifdef ECLK_SCHED_TIMEOUT_EN
      err       <= 1'b0;
      to_cnt    <= '0;
`endif
    end else begin
      ack <= '0;
`ifdef ECLK_SCHED_TIMEOUT_EN
      err <= 1'b0;
`endif
      if (clk7_en) begin
        case (state)
          ST_IDLE: begin
            if (arb_valid) begin
              gnt       <= arb_grant;
              lat_we    <= we[arb_grant];
              cia_addr  <= arb_grant ? addr1 : addr0;
              cia_wdata <= arb_grant ? wdata1 : wdata0;
`ifdef ECLK_SCHED_TIMEOUT_EN
              to_cnt    <= '0;
`endif
              // Granting on the phase-5 boundary skips WAIT entirely.
              if (ph_start) begin
                state   <= ST_ACTIVE;
                cia_sel <= 1'b1;
                cia_we  <= we[arb_grant];
              end else begin
                state   <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (ph_start) begin
              state   <= ST_ACTIVE;
              cia_sel <= 1'b1;
              cia_we  <= lat_we;
            end
`ifdef ECLK_SCHED_TIMEOUT_EN
            else if (to_hit) begin
              ack[gnt] <= 1'b1;
              err      <= 1'b1;
              rdata    <= RD_ERR_VAL;
              state    <= ST_RECOVER;
            end else begin
              to_cnt   <= to_cnt + 1'b1;
            end
`endif
          end
          ST_ACTIVE: begin
            // Phase 9 end is the falling edge of E: the CIA latches writes
            // here and read data is valid to capture.
            if (ph_last) begin
              if (!lat_we) rdata <= cia_rdata;
              ack[gnt] <= 1'b1;
              cia_sel  <= 1'b0;
              cia_we   <= 1'b0;
              state    <= ST_RECOVER;
            end
          end
          ST_RECOVER: state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eclk_access_sched.sv
// tb/tb_eclk_access_sched.sv - directed self-checking bench for eclk_access_sched
module tb_eclk_access_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk7_en;
  logic [9:0] eclk;
  logic [1:0] req;
  logic [1:0] we;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] ack;
  logic       err;
  logic [7:0] rdata;
  logic       cia_sel;
  logic       cia_we;
  logic [3:0] cia_addr;
  logic [7:0] cia_wdata;
  logic [7:0] cia_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int g_div    = 0;
  int g_ph     = 0;
  bit eclk_zero = 1'b0;

  eclk_access_sched #(.ADDR_W(4), .TO_PHASES(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk7_en   (clk7_en),
    .eclk      (eclk),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .cia_sel   (cia_sel),
    .cia_we    (cia_we),
    .cia_addr  (cia_addr),
    .cia_wdata (cia_wdata),
    .cia_rdata (cia_rdata)
  );

  always #5 clk = ~clk;

  // clk7_en every 4th clk; the E phase advances after each clk7_en cycle.
  initial begin
    clk7_en = 1'b0;
    eclk    = 10'd1;
    forever begin
      @(negedge clk);
      if (clk7_en) g_ph = (g_ph + 1) % 10;
      g_div   = (g_div + 1) % 4;
      clk7_en = (g_div == 3);
      eclk    = eclk_zero ? 10'd0 : (10'd1 << g_ph);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input int k);
    int n;
    n = 0;
    tick();
    while (!(clk7_en && eclk == (10'd1 << k)) && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("wait_ph%0d_bound", k), 32'(n >= 60), 0);
  endtask

  // Runs until an ack pulse, counting clk7_en boundaries seen by the DUT,
  // samples with cia_sel high, and samples where the CIA bus differs from
  // the expected access.
  task automatic run_to_ack(input string tag, input logic exp_we, input logic [3:0] exp_addr,
                            input logic [7:0] exp_wdata, input bit chk_wdata,
                            output int n7, output int sel_cnt, output int bad);
    int n;
    bit got;
    n = 0; n7 = 0; sel_cnt = 0; bad = 0; got = 1'b0;
    while (!got && n < 400) begin
      tick();
      n++;
      if (clk7_en) n7++;
      if (ack != 2'b00) begin
        got = 1'b1;
      end else if (cia_sel) begin
        sel_cnt++;
        if (cia_we !== exp_we || cia_addr !== exp_addr || (chk_wdata && cia_wdata !== exp_wdata))
          bad++;
      end
    end
    check({tag, "_ack_seen"}, 32'(got), 1);
  endtask

  int n7, sel_cnt, bad;

  initial begin
    rst_n = 1'b0;
    req = 2'b00; we = 2'b00;
    addr0 = 4'h0; addr1 = 4'h0; wdata0 = 8'h00; wdata1 = 8'h00;
    cia_rdata = 8'h00;
    tick(); tick();

    // Reset state
    check("rst_cia_sel", 32'(cia_sel), 0);
    check("rst_cia_we", 32'(cia_we), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_cia_addr", 32'(cia_addr), 0);
    check("rst_cia_wdata", 32'(cia_wdata), 0);
    rst_n = 1'b1;
    tick();

    // Contention right after reset, both held: 0, 1, 0, 1
    addr0 = 4'h1; addr1 = 4'h2; cia_rdata = 8'h11;
    req = 2'b11;
    run_to_ack("cont0", 1'b0, 4'h1, 8'h00, 1'b0, n7, sel_cnt, bad);
    check("cont0_ack", 32'(ack), 'b01);
    check("cont0_bus", 32'(bad), 0);
    run_to_ack("cont1", 1'b0, 4'h2, 8'h00, 1'b0, n7, sel_cnt, bad);
    check("cont1_ack", 32'(ack), 'b10);
    check("cont1_n7", 32'(n7), 10);
    check("cont1_bus", 32'(bad), 0);
    run_to_ack("cont2", 1'b0, 4'h1, 8'h00, 1'b0, n7, sel_cnt, bad);
    check("cont2_ack", 32'(ack), 'b01);
    check("cont2_n7", 32'(n7), 10);
    run_to_ack("cont3", 1'b0, 4'h2, 8'h00, 1'b0, n7, sel_cnt, bad);
    check("cont3_ack", 32'(ack), 'b10);
    req = 2'b00;
    tick();

    // Single read, request mid phase 2
    wait_phase(1);
    tick(); tick();
    addr0 = 4'h3; wdata0 = 8'h11; we = 2'b00; cia_rdata = 8'h5A;
    req = 2'b01;
    run_to_ack("rd", 1'b0, 4'h3, 8'h00, 1'b0, n7, sel_cnt, bad);
    check("rd_ack", 32'(ack), 'b01);
    check("rd_err", 32'(err), 0);
    check("rd_rdata", 32'(rdata), 'h5A);
    check("rd_sel_len", 32'(sel_cnt), 16);
    check("rd_n7", 32'(n7), 8);
    check("rd_bus", 32'(bad), 0);
    req = 2'b00;
    tick();
    check("rd_ack_one_clk", 32'(ack), 0);

    // Write from port 1; rdata must keep the last read value
    addr1 = 4'hE; wdata1 = 8'hC3; we = 2'b10; cia_rdata = 8'h99;
    req = 2'b10;
    run_to_ack("wr", 1'b1, 4'hE, 8'hC3, 1'b1, n7, sel_cnt, bad);
    check("wr_ack", 32'(ack), 'b10);
    check("wr_rdata_kept", 32'(rdata), 'h5A);
    check("wr_sel_len", 32'(sel_cnt), 16);
    check("wr_bus", 32'(bad), 0);
    req = 2'b00; we = 2'b00;
    tick();

    // Grant on the phase-5 boundary: straight to ACTIVE
    wait_phase(4);
    addr0 = 4'h7; cia_rdata = 8'h27;
    req = 2'b01;
    run_to_ack("ph5", 1'b0, 4'h7, 8'h00, 1'b0, n7, sel_cnt, bad);
    check("ph5_ack", 32'(ack), 'b01);
    check("ph5_n7", 32'(n7), 5);
    check("ph5_rdata", 32'(rdata), 'h27);
    check("ph5_sel_len", 32'(sel_cnt), 16);
    req = 2'b00;
    tick();

    // Reset mid-ACTIVE during phase 7
    addr1 = 4'h5;
    req = 2'b10;
    wait_phase(6);
    tick(); tick();
    check("mid_sel_pre", 32'(cia_sel), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_sel_async", 32'(cia_sel), 0);
    check("mid_ack", 32'(ack), 0);
    check("mid_rdata", 32'(rdata), 0);
    check("mid_cia_addr", 32'(cia_addr), 0);
    check("mid_cia_we", 32'(cia_we), 0);
    tick(); tick(); tick();
    check("mid_ack_held", 32'(ack), 0);
    rst_n = 1'b1;
    addr0 = 4'h2; addr1 = 4'h4;
    req = 2'b11;
    run_to_ack("post_rst0", 1'b0, 4'h2, 8'h00, 1'b0, n7, sel_cnt, bad);
    check("post_rst0_ack", 32'(ack), 'b01);
    req = 2'b10;
    run_to_ack("post_rst1", 1'b0, 4'h4, 8'h00, 1'b0, n7, sel_cnt, bad);
    check("post_rst1_ack", 32'(ack), 'b10);
    req = 2'b00;
    tick();

`ifdef ECLK_SCHED_TIMEOUT_EN
    // Stalled eclk: grant, 20 WAIT boundaries, then abort with err
    wait_phase(2);
    eclk_zero = 1'b1;
    req = 2'b01;
    run_to_ack("to", 1'b0, 4'h2, 8'h00, 1'b0, n7, sel_cnt, bad);
    check("to_ack", 32'(ack), 'b01);
    check("to_err", 32'(err), 1);
    check("to_rdata", 32'(rdata), 'hFF);
    check("to_sel_never", 32'(sel_cnt), 0);
    check("to_n7", 32'(n7), 21);
    req = 2'b00;
    eclk_zero = 1'b0;
    tick();
    check("to_err_one_clk", 32'(err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
